image_streamer: RTL

Host-side source for the `regnet` pixel input port. Buffers one image of fixed-point pixels written by a host port and, on `start`, streams it into `regnet` as `INPUT_SIZE` pixels per cycle with `image_ready` high. Then waits for `label_ready`, captures the predicted `label` and reports it to the host. Sits between the host/loader logic and `regnet` in the top level.

---
 rtl/image_streamer_if.sv | 41 ++++
 rtl/image_streamer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/image_streamer_if.sv
// image_streamer_if: host write port, start/status and the regnet pixel/label
// handshake of image_streamer bundled together. The streamer connects
// through the slave modport. The host or loader connects through master.
`timescale 1ns/1ps

interface image_streamer_if #(
    parameter int NUM_PIXELS     = 10,
    parameter int INPUT_SIZE     = 1,
    parameter int NUM_CLASSES    = 10,
    parameter int INTEGER_WIDTH  = 8,
    parameter int FRACTION_WIDTH = 8
);
    localparam int AW = (NUM_PIXELS  > 1) ? $clog2(NUM_PIXELS)  : 1;
    localparam int LW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

    // host write port
    logic                                           wr_en;
    logic [AW-1:0]                                  wr_addr;
    logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH]  wr_data;
    // run control / status
    logic                                           start;
    logic                                           busy;
    logic [LW-1:0]                                  result_label;
    logic                                           result_valid;
    logic                                           timeout;
    // regnet side
    logic                                           image_ready;
    logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH]  pixels [INPUT_SIZE];
    logic                                           label_ready;
    logic [LW-1:0]                                  label;

    modport master (
        output wr_en, wr_addr, wr_data, start, label_ready, label,
        input  busy, image_ready, pixels, result_label, result_valid, timeout
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, label_ready, label,
        output busy, image_ready, pixels, result_label, result_valid, timeout
    );
endinterface

// File: rtl/image_streamer.sv
// image_streamer: buffers one image written by the host and streams it into
// regnet INPUT_SIZE pixels per cycle on start. It then waits for label_ready
// and captures the predicted label.
// Optional feature macro: IMAGE_STREAMER_TIMEOUT_EN. When it is defined, the
// WAIT state gives up after TIMEOUT_CYCLES cycles without label_ready.
`timescale 1ns/1ps

module image_streamer #(
    parameter int NUM_PIXELS     = 10,
    parameter int INPUT_SIZE     = 1,
    parameter int NUM_CLASSES    = 10,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int INTEGER_WIDTH  = 8,
    parameter int FRACTION_WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    image_streamer_if.slave    bus
);
    localparam int NUM_GROUPS = (NUM_PIXELS + INPUT_SIZE - 1) / INPUT_SIZE;
    localparam int GW         = (NUM_GROUPS  > 1) ? $clog2(NUM_GROUPS)  : 1;
    localparam int AW         = (NUM_PIXELS  > 1) ? $clog2(NUM_PIXELS)  : 1;
    localparam int LW         = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

    typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] pixel_t;
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_DONE} state_t;

    state_t          r_state, w_state_next;
    logic [GW-1:0]   r_group, w_group_next;
    logic            r_busy;
    logic            r_image_ready;
    logic            r_result_valid, w_result_valid_next;
    logic [LW-1:0]   r_result_label, w_result_label_next;
    pixel_t          r_buffer [NUM_PIXELS];
    pixel_t          w_pixels [INPUT_SIZE];
    logic            w_wr_accept;

`ifdef IMAGE_STREAMER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]   r_wait_cnt, w_wait_cnt_next;
    logic            r_timeout, w_timeout_next;
`endif

    // Host writes land only while no run is in progress and only in range.
    assign w_wr_accept = bus.wr_en
                       && (r_state == S_IDLE || r_state == S_DONE)
                       && (32'(bus.wr_addr) < 32'(NUM_PIXELS));

    // Pixel buffer: not reset, so an image survives a run abort.
    always_ff @(posedge clock) begin
        if (w_wr_accept)
            r_buffer[bus.wr_addr] <= bus.wr_data;
    end

    // Next-state, group counter and result capture.
    always_comb begin
        w_state_next        = r_state;
        w_group_next        = r_group;
        w_result_valid_next = r_result_valid;
        w_result_label_next = r_result_label;
`ifdef IMAGE_STREAMER_TIMEOUT_EN
        w_wait_cnt_next     = r_wait_cnt;
        w_timeout_next      = r_timeout;
`endif
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_next        = S_STREAM;
                    w_group_next        = '0;
                    w_result_valid_next = 1'b0;
`ifdef IMAGE_STREAMER_TIMEOUT_EN
                    w_timeout_next      = 1'b0;
                    w_wait_cnt_next     = '0;
`endif
                end
            end
            S_STREAM: begin
                if (r_group == GW'(NUM_GROUPS - 1)) begin
                    w_state_next = S_WAIT;
                    w_group_next = '0;
                end else begin
                    w_group_next = r_group + 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.label_ready) begin
                    w_state_next        = S_DONE;
                    w_result_label_next = bus.label;
                    w_result_valid_next = 1'b1;
                end
`ifdef IMAGE_STREAMER_TIMEOUT_EN
                else if (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_state_next        = S_DONE;
                    w_result_label_next = '0;
                    w_result_valid_next = 1'b1;
                    w_timeout_next      = 1'b1;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 1'b1;
                end
`endif
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State and registered control outputs, decoded from the next state so
    // they change at the same edge as the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_group        <= '0;
            r_busy         <= 1'b0;
            r_image_ready  <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_label <= '0;
`ifdef IMAGE_STREAMER_TIMEOUT_EN
            r_wait_cnt     <= '0;
            r_timeout      <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_next;
            r_group        <= w_group_next;
            r_busy         <= (w_state_next == S_STREAM) || (w_state_next == S_WAIT);
            r_image_ready  <= (w_state_next == S_STREAM);
            r_result_valid <= w_result_valid_next;
            r_result_label <= w_result_label_next;
`ifdef IMAGE_STREAMER_TIMEOUT_EN
            r_wait_cnt     <= w_wait_cnt_next;
            r_timeout      <= w_timeout_next;
`endif
        end
    end

    // Pixel lanes: current group while streaming. Padding lanes past the
    // end of the image and all lanes outside STREAM are zero.
    always_comb begin
        for (int unsigned i = 0; i < INPUT_SIZE; i++) begin
            int unsigned idx;
            idx         = 32'(r_group) * 32'(INPUT_SIZE) + i;
            w_pixels[i] = '0;
            if (r_state == S_STREAM && idx < 32'(NUM_PIXELS))
                w_pixels[i] = r_buffer[idx[AW-1:0]];
        end
    end

    assign bus.pixels       = w_pixels;
    assign bus.busy         = r_busy;
    assign bus.image_ready  = r_image_ready;
    assign bus.result_valid = r_result_valid;
    assign bus.result_label = r_result_label;
`ifdef IMAGE_STREAMER_TIMEOUT_EN
    assign bus.timeout      = r_timeout;
`else
    assign bus.timeout      = 1'b0;
`endif

endmodule
